inv_mix_columns_seq: RTL and testbench

INV_MIX_COLUMNS_SEQ -- requirements
Module: inv_mix_columns_seq

---
 rtl/inv_mix_columns_seq_if.sv | 35 +++
 rtl/inv_mix_columns_seq.sv | 135 +++++++++++++
 tb/tb_inv_mix_columns_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/inv_mix_columns_seq_if.sv
// inv_mix_columns_seq_if -- request/response bundle for inv_mix_columns_seq.
//
// Handshake: the master raises start with state_in valid. The block samples
// start only while busy=0. A sampled start is accepted, and state_in is
// captured on that same edge. done is a one-cycle pulse, and state_out is
// valid from that cycle until the next done. start held high during the done
// cycle is accepted on the next edge.
//
// Signals:
//   start     master->slave  request strobe
//   state_in  master->slave  128-bit AES state, byte k at [127-8k -: 8]
//   busy      slave->master  transform in progress
//   done      slave->master  single-cycle completion pulse
//   state_out slave->master  InvMixColumns result, held between completions
//   dbg_state slave->master  FSM state (0 = IDLE, 1 = PROC)
//   dbg_col   slave->master  column counter
interface inv_mix_columns_seq_if;
  logic         start;
  logic [127:0] state_in;
  logic         busy;
  logic         done;
  logic [127:0] state_out;
  logic         dbg_state;
  logic [1:0]   dbg_col;

  modport master (
    output start, state_in,
    input  busy, done, state_out, dbg_state, dbg_col
  );

  modport slave (
    input  start, state_in,
    output busy, done, state_out, dbg_state, dbg_col
  );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq -- sequential AES InvMixColumns, one column per cycle.
//
// The block captures state_in on the accepting edge (E0). It then transforms
// columns 0..3 on edges E1..E4 through a single four-byte GF(2^8) multiplier
// bank. On E4 it publishes the full result on state_out and pulses done.
//
// Ports:
//   clk    system clock, rising edge
//   n_rst  synchronous active-low reset
//   bus    inv_mix_columns_seq_if.slave (start, state_in, busy, done,
//          state_out, dbg_state, dbg_col)
module inv_mix_columns_seq (
  input  logic                        clk,
  input  logic                        n_rst,
  inv_mix_columns_seq_if.slave        bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PROC = 1'b1;

  logic [0:0]   state_q;
  logic [1:0]   col_q;
  logic [127:0] work_q;
  logic [127:0] out_q;
  logic         busy_q;
  logic         done_q;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column currently addressed by col_q
  logic [31:0] col_word;
  always_comb begin
    col_word = work_q[127:96];
    case (col_q)
      2'd0: col_word = work_q[127:96];
      2'd1: col_word = work_q[95:64];
      2'd2: col_word = work_q[63:32];
      2'd3: col_word = work_q[31:0];
      default: col_word = work_q[127:96];
    endcase
  end

  // Shared multiplier bank: x9, x11, x13, x14 of each byte of the column
  logic [7:0] a   [4];
  logic [7:0] m9  [4];
  logic [7:0] m11 [4];
  logic [7:0] m13 [4];
  logic [7:0] m14 [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      logic [7:0] x2, x4, x8;
      a[i]   = col_word[31-8*i -: 8];
      x2     = xtime(a[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
  end

  logic [31:0] col_res;
  always_comb begin
    col_res[31:24] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
    col_res[23:16] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
    col_res[15:8]  = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
    col_res[7:0]   = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
  end

  // Work register with the current column replaced by its result
  logic [127:0] next_work;
  always_comb begin
    next_work = work_q;
    case (col_q)
      2'd0: next_work[127:96] = col_res;
      2'd1: next_work[95:64]  = col_res;
      2'd2: next_work[63:32]  = col_res;
      2'd3: next_work[31:0]   = col_res;
      default: next_work = work_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      work_q  <= 128'h0;
      out_q   <= 128'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          col_q <= 2'd0;
          if (bus.start) begin
            work_q  <= bus.state_in;
            busy_q  <= 1'b1;
            state_q <= PROC;
          end
        end
        PROC: begin
          work_q <= next_work;
          if (col_q == 2'd3) begin
            // next_work already holds all four transformed columns
            out_q   <= next_work;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            col_q   <= 2'd0;
            state_q <= IDLE;
          end else begin
            col_q <= col_q + 2'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          col_q   <= 2'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_out = out_q;
  assign bus.dbg_state = state_q[0];
  assign bus.dbg_col   = col_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb_inv_mix_columns_seq -- directed and randomized bench for
// inv_mix_columns_seq. The reference model uses a generic GF(2^8) multiply
// with a coefficient-rotation matrix for both the inverse and forward
// MixColumns.
module tb_inv_mix_columns_seq;

  logic clk;
  logic n_rst;
  int   n_vec;
  int   n_err;

  inv_mix_columns_seq_if bus ();

  inv_mix_columns_seq dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = x;
    bb = y;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // r_i = XOR_j coef[(j-i) mod 4] * a_j, per column
  function automatic logic [127:0] mix_model(input logic [127:0] s, input logic inverse);
    logic [7:0]   coef [4];
    logic [127:0] r;
    logic [7:0]   acc;
    logic [1:0]   k;
    if (inverse) begin
      coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
    end else begin
      coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1;
    end
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          k   = 2'(j - i);
          acc = acc ^ gmul(coef[k], s[127-8*(4*c+j) -: 8]);
        end
        r[127-8*(4*c+i) -: 8] = acc;
      end
    end
    return r;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start a transform and wait (bounded) for done; returns result and latency
  task automatic do_transform(input string tag, input logic [127:0] s,
                              output logic [127:0] res, output int lat);
    bus.state_in = s;
    bus.start    = 1'b1;
    tick();                                  // E0
    bus.start = 1'b0;
    check({tag, "_busy_e0"}, 128'(bus.busy), 128'd1);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (bus.done === 1'b1) break;
    end
    check({tag, "_latency"}, 128'(lat), 128'd4);
    res = bus.state_out;
  endtask

  localparam logic [127:0] KV_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] KV_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] UNI    = {4{32'hc6c6c6c6}};
  localparam logic [127:0] B2B_IN = {4{32'h4d7ebdf8}};
  localparam logic [127:0] B2B_OUT= {4{32'h2d26314c}};
  localparam logic [127:0] ALL_FF = {128{1'b1}};

  initial begin
    logic [127:0] res, s, held;
    int           lat;
    logic         saw_done;

    n_vec = 0;
    n_err = 0;
    n_rst = 1'b0;
    bus.start    = 1'b0;
    bus.state_in = 128'h0;

    // reset state
    tick();
    tick();
    check("rst_busy",  128'(bus.busy),      128'd0);
    check("rst_done",  128'(bus.done),      128'd0);
    check("rst_out",   bus.state_out,       128'h0);
    check("rst_state", 128'(bus.dbg_state), 128'd0);
    check("rst_col",   128'(bus.dbg_col),   128'd0);
    n_rst = 1'b1;
    tick();

    // known vector
    do_transform("kv", KV_IN, res, lat);
    check("kv_out", res, KV_OUT);
    check("kv_model", res, mix_model(KV_IN, 1'b1));
    tick();
    check("kv_done_pulse", 128'(bus.done), 128'd0);
    check("kv_hold", bus.state_out, KV_OUT);

    // uniform column
    do_transform("uni", UNI, res, lat);
    check("uni_out", res, UNI);
    tick();

    // start held for 6 cycles, state_in changes at E2
    bus.state_in = KV_IN;
    bus.start    = 1'b1;
    tick();                                  // E0
    tick();                                  // E1
    tick();                                  // E2
    bus.state_in = ALL_FF;
    check("ign_col_mid", 128'(bus.dbg_col), 128'd2);
    tick();                                  // E3
    check("ign_no_early_done", 128'(bus.done), 128'd0);
    check("ign_out_held", bus.state_out, UNI);
    tick();                                  // E4
    check("ign_done", 128'(bus.done), 128'd1);
    check("ign_out1", bus.state_out, KV_OUT);
    tick();                                  // E5 = second E0
    bus.start = 1'b0;
    check("ign_b2b_busy", 128'(bus.busy), 128'd1);
    check("ign_b2b_done_low", 128'(bus.done), 128'd0);
    tick();
    tick();
    check("ign_out_mid", bus.state_out, KV_OUT);
    tick();
    tick();
    check("ign_done2", 128'(bus.done), 128'd1);
    check("ign_out2", bus.state_out, mix_model(ALL_FF, 1'b1));
    tick();

    // back-to-back with start re-asserted in the done cycle
    s = {$urandom, $urandom, $urandom, $urandom};
    do_transform("b2b_first", s, res, lat);
    check("b2b_first_out", res, mix_model(s, 1'b1));
    do_transform("b2b_second", B2B_IN, res, lat);
    check("b2b_second_out", res, B2B_OUT);
    tick();

    // reset asserted at E2 of a transform
    bus.state_in = KV_IN;
    bus.start    = 1'b1;
    tick();                                  // E0
    bus.start = 1'b0;
    tick();                                  // E1
    n_rst = 1'b0;
    tick();                                  // E2
    check("abort_busy", 128'(bus.busy), 128'd0);
    check("abort_done", 128'(bus.done), 128'd0);
    check("abort_out",  bus.state_out,  128'h0);
    check("abort_col",  128'(bus.dbg_col), 128'd0);
    n_rst = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", 128'(saw_done), 128'd0);
    check("abort_out_after", bus.state_out, 128'h0);
    do_transform("post_rst", UNI, res, lat);
    check("post_rst_out", res, UNI);

    // randomized, closed through the forward transform
    for (int n = 0; n < 24; n++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1) tick();
      do_transform("rnd", s, res, lat);
      held = res;
      check("rnd_inv", res, mix_model(s, 1'b1));
      check("rnd_roundtrip", mix_model(res, 1'b0), s);
      tick();
      check("rnd_hold", bus.state_out, held);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
